alu_arbiter: RTL and testbench

Shares one `alu` instance between two requesters, port 0 and port 1. Each port uses a valid/ready request channel and a valid/ready response channel. The arbiter grants round-robin, registers the granted operands, drives the shared ALU for one cycle, and registers the result. It holds the result until the owning port accepts it, with exactly one transaction in flight at a time.

---
 rtl/alu_arbiter.sv | 160 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// One transaction in flight: IDLE accepts, EXEC samples the ALU, RESP holds the result.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_op1,
    input  logic [DATA_WIDTH-1:0] req0_op2,
    input  logic [2:0]            req0_ctrl,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_op1,
    input  logic [DATA_WIDTH-1:0] req1_op2,
    input  logic [2:0]            req1_ctrl,

    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_WIDTH-1:0] rsp0_data,
    output logic                  rsp0_zero,

    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp1_data,
    output logic                  rsp1_zero,

    output logic [DATA_WIDTH-1:0] alu_op1,
    output logic [DATA_WIDTH-1:0] alu_op2,
    output logic [2:0]            alu_ctrl,
    input  logic [DATA_WIDTH-1:0] alu_sum,
    input  logic                  alu_zero,

    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic                  owner_q, owner_d;
    logic [DATA_WIDTH-1:0] op1_q, op1_d;
    logic [DATA_WIDTH-1:0] op2_q, op2_d;
    logic [2:0]            ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  zero_q, zero_d;
    logic                  rsp0_valid_q, rsp0_valid_d;
    logic                  rsp1_valid_q, rsp1_valid_d;
    logic                  busy_q, busy_d;

    logic                  grant;
    logic                  in_idle;
    logic                  handshake;
    logic                  owner_rsp_ready;

    // Grant is only consulted in IDLE; ready is masked during reset.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = ptr_q;
        end else begin
            grant = req1_valid;
        end
        in_idle    = (state_q == IDLE) && !rst;
        req0_ready = in_idle && req0_valid && !grant;
        req1_ready = in_idle && req1_valid && grant;
        handshake  = req0_ready || req1_ready;
    end

    assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        ctrl_d  = ctrl_q;
        res_d   = res_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: begin
                if (handshake) begin
                    op1_d   = grant ? req1_op1  : req0_op1;
                    op2_d   = grant ? req1_op2  : req0_op2;
                    ctrl_d  = grant ? req1_ctrl : req0_ctrl;
                    owner_d = grant;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_sum;
                zero_d  = alu_zero;
                state_d = RESP;
            end
            RESP: begin
                // The non-owner's rsp_ready never reaches this decision.
                if (owner_rsp_ready) begin
                    ptr_d   = ~owner_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rsp0_valid_d = (state_d == RESP) && !owner_d;
        rsp1_valid_d = (state_d == RESP) && owner_d;
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= 1'b0;
            owner_q      <= 1'b0;
            op1_q        <= '0;
            op2_q        <= '0;
            ctrl_q       <= 3'b000;
            res_q        <= '0;
            zero_q       <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            ctrl_q       <= ctrl_d;
            res_q        <= res_d;
            zero_q       <= zero_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign alu_op1    = op1_q;
    assign alu_op2    = op2_q;
    assign alu_ctrl   = ctrl_q;

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_data  = res_q;
    assign rsp1_data  = res_q;
    assign rsp0_zero  = zero_q;
    assign rsp1_zero  = zero_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, transaction-level reference model,
// directed scenarios followed by constrained-random traffic.
`timescale 1ns/1ps
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic [2:0]   req0_ctrl, req1_ctrl;
    logic         rsp0_valid, rsp0_ready, rsp0_zero;
    logic         rsp1_valid, rsp1_ready, rsp1_zero;
    logic [W-1:0] rsp0_data, rsp1_data;
    logic [W-1:0] alu_op1, alu_op2, alu_sum;
    logic [2:0]   alu_ctrl;
    logic         alu_zero;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: one transaction in flight, age counts edges since acceptance.
    bit           m_busy = 0;
    int           m_age  = 0;
    int           m_port = 0;
    int           m_ptr  = 0;
    logic [W-1:0] m_op1 = '0, m_op2 = '0, m_data = '0;
    logic [2:0]   m_ctrl = '0;
    logic         m_zero = 1'b0;
    bit           acc0, acc1;
    int           g_port[$];
    int           g_cyc[$];

    alu_arbiter #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_ctrl(req1_ctrl),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_data(rsp0_data), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_data(rsp1_data), .rsp1_zero(rsp1_zero),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
        .alu_sum(alu_sum), .alu_zero(alu_zero),
        .busy(busy)
    );

    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] c);
        case (c)
            3'b001:  return b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b101:  return (a < b) ? 32'd1 : 32'd0;
            default: return a + b;
        endcase
    endfunction

    assign alu_sum  = alu_fn(alu_op1, alu_op2, alu_ctrl);
    assign alu_zero = (alu_op1 == alu_op2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Check the DUT against the model for this cycle, then advance one clock.
    task automatic step();
        int  g;
        bit  e_r0, e_r1, e_v0, e_v1;
        #1;
        g    = (req0_valid && req1_valid) ? m_ptr : (req1_valid ? 1 : 0);
        e_r0 = !rst && !m_busy && req0_valid && (g == 0);
        e_r1 = !rst && !m_busy && req1_valid && (g == 1);
        e_v0 = m_busy && (m_age >= 2) && (m_port == 0);
        e_v1 = m_busy && (m_age >= 2) && (m_port == 1);
        check("req0_ready", req0_ready, e_r0);
        check("req1_ready", req1_ready, e_r1);
        check("busy", busy, m_busy);
        check("rsp0_valid", rsp0_valid, e_v0);
        check("rsp1_valid", rsp1_valid, e_v1);
        check("alu_op1", alu_op1, m_op1);
        check("alu_op2", alu_op2, m_op2);
        check("alu_ctrl", alu_ctrl, m_ctrl);
        if (e_v0) begin
            check("rsp0_data", rsp0_data, m_data);
            check("rsp0_zero", rsp0_zero, m_zero);
        end
        if (e_v1) begin
            check("rsp1_data", rsp1_data, m_data);
            check("rsp1_zero", rsp1_zero, m_zero);
        end
        if (req0_ready === 1'b1) begin g_port.push_back(0); g_cyc.push_back(cyc); end
        if (req1_ready === 1'b1) begin g_port.push_back(1); g_cyc.push_back(cyc); end
        acc0 = e_r0;
        acc1 = e_r1;
        @(posedge clk);
        if (rst) begin
            m_busy = 0; m_ptr = 0; m_op1 = '0; m_op2 = '0; m_ctrl = '0;
        end else if (e_r0 || e_r1) begin
            m_busy = 1;
            m_age  = 1;
            m_port = g;
            m_op1  = (g == 1) ? req1_op1  : req0_op1;
            m_op2  = (g == 1) ? req1_op2  : req0_op2;
            m_ctrl = (g == 1) ? req1_ctrl : req0_ctrl;
            m_data = alu_fn(m_op1, m_op2, m_ctrl);
            m_zero = (m_op1 == m_op2);
        end else if (m_busy) begin
            if (m_age >= 2 && ((m_port == 0) ? rsp0_ready : rsp1_ready)) begin
                m_busy = 0;
                m_ptr  = 1 - m_port;
            end else if (m_age < 2) begin
                m_age++;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_req0(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2:0] c);
        req0_valid = v; req0_op1 = a; req0_op2 = b; req0_ctrl = c;
    endtask

    task automatic set_req1(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2:0] c);
        req1_valid = v; req1_op1 = a; req1_op2 = b; req1_ctrl = c;
    endtask

    task automatic drain();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (4) step();
    endtask

    initial begin
        rst = 1'b1;
        set_req0(1'b0, '0, '0, 3'b000);
        set_req1(1'b0, '0, '0, 3'b000);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);

        // Reset state, with a request present that must not be accepted.
        req0_valid = 1'b1;
        step();
        check("rst_req0_ready", req0_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rsp0_valid", rsp0_valid, 1'b0);
        check("rst_rsp1_valid", rsp1_valid, 1'b0);
        check("rst_rsp0_data", rsp0_data, 32'd0);
        check("rst_alu_op1", alu_op1, 32'd0);

        // Single port0 transaction: 5 + 7.
        rst = 1'b0;
        set_req0(1'b1, 32'd5, 32'd7, 3'b000);
        step();
        req0_valid = 1'b0;
        step();
        check("t1_rsp0_valid", rsp0_valid, 1'b1);
        check("t1_rsp0_data", rsp0_data, 32'd12);
        check("t1_rsp0_zero", rsp0_zero, 1'b0);
        check("t1_rsp1_valid", rsp1_valid, 1'b0);
        drain();

        // Both ports valid from reset: alternating grants, 3 cycles apart.
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req0(1'b1, 32'd3, 32'd3, 3'b010);
        set_req1(1'b1, 32'd1, 32'd2, 3'b101);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        g_port.delete(); g_cyc.delete();
        repeat (13) step();
        check("rr_grant_count", g_port.size(), 5);
        for (int i = 0; i < 4 && i < g_port.size(); i++) begin
            check("rr_grant_port", g_port[i], i % 2);
            if (i > 0) check("rr_grant_spacing", g_cyc[i] - g_cyc[i-1], 3);
        end
        drain();

        // Port1 OR with a 5-cycle response stall while port0 waits.
        set_req1(1'b1, 32'h0000_00F0, 32'h0000_000F, 3'b011);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        step();
        req1_valid = 1'b0;
        set_req0(1'b1, 32'd11, 32'd22, 3'b000);
        step();
        rsp0_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stall_rsp1_valid", rsp1_valid, 1'b1);
            check("stall_rsp1_data", rsp1_data, 32'hFF);
            check("stall_req0_ready", req0_ready, 1'b0);
            check("stall_busy", busy, 1'b1);
            step();
        end
        rsp1_ready = 1'b1;
        step();
        check("stall_req0_granted", req0_ready, 1'b1);
        step();
        drain();

        // Reset while port0's response is pending.
        set_req0(1'b1, 32'hA5, 32'h5A, 3'b000);
        rsp0_ready = 1'b0;
        step();
        req0_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        req0_valid = 1'b1;
        #1;
        check("mid_rst_req0_ready", req0_ready, 1'b0);
        check("mid_rst_rsp0_valid", rsp0_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_alu_op1", alu_op1, 32'd0);
        check("mid_rst_alu_ctrl", alu_ctrl, 3'b000);
        step();
        rst = 1'b0;
        req0_valid = 1'b0;
        rsp0_ready = 1'b1;
        repeat (3) step();
        set_req1(1'b1, 32'd6, 32'd3, 3'b000);
        step();
        req1_valid = 1'b0;
        step();
        check("post_rst_rsp1_valid", rsp1_valid, 1'b1);
        check("post_rst_rsp1_data", rsp1_data, 32'd9);
        drain();

        // Unused control code falls back to add and wraps.
        set_req0(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b111);
        rsp0_ready = 1'b0;
        step();
        req0_valid = 1'b0;
        step();
        check("wrap_rsp0_valid", rsp0_valid, 1'b1);
        check("wrap_rsp0_data", rsp0_data, 32'd0);
        check("wrap_rsp0_zero", rsp0_zero, 1'b0);
        drain();

        // Pass op2, then port1 alone is granted with ptr already on it.
        set_req0(1'b1, 32'd9, 32'h0000_ABCD, 3'b001);
        rsp0_ready = 1'b0;
        step();
        req0_valid = 1'b0;
        step();
        check("pass_rsp0_data", rsp0_data, 32'hABCD);
        rsp0_ready = 1'b1;
        step();
        set_req1(1'b1, 32'd4, 32'd4, 3'b000);
        #1;
        check("ptr1_req1_ready", req1_ready, 1'b1);
        step();
        drain();

        // Random traffic: a pending request keeps its data until accepted.
        acc0 = 1'b1; acc1 = 1'b1;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            if (!(req0_valid && !acc0) || $urandom_range(0, 7) == 0)
                set_req0($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0 ? 32'd7 : $urandom,
                         $urandom_range(0, 3) == 0 ? 32'd7 : $urandom, 3'($urandom_range(0, 7)));
            if (!(req1_valid && !acc1) || $urandom_range(0, 7) == 0)
                set_req1($urandom_range(0, 1) == 1, $urandom, $urandom, 3'($urandom_range(0, 7)));
            rsp0_ready = $urandom_range(0, 1) == 1;
            rsp1_ready = $urandom_range(0, 1) == 1;
            step();
        end
        rst = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
